// File: rtl/axi4_burst_ram_pkg.sv
// axi4_burst_ram_pkg: shared AXI encodings and FSM state types for the burst RAM
// Exports: BURST_* burst codes, RESP_OKAY, w_state_t and r_state_t
package axi4_burst_ram_pkg;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;
endpackage

// File: rtl/axi4_burst_addr_next.sv
// axi4_burst_addr_next: combinational next-beat address for an AXI burst
// Ports: addr/size/burst in, next out; FIXED holds, every other burst type increments by 1<<size
module axi4_burst_addr_next
    import axi4_burst_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 16
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [2:0]            size,
    input  logic [1:0]            burst,
    output logic [ADDR_WIDTH-1:0] next
);
    always_comb next = (burst == BURST_FIXED) ? addr : addr + (ADDR_WIDTH'(1) << size);
endmodule

// File: rtl/axi4_burst_ram.sv
// axi4_burst_ram: AXI4 slave RAM with independent, concurrent read and write burst engines
// Ports: clk, rst (sync, active high); AXI4 AW/W/B write channels and AR/R read channels (s_axi_*)
module axi4_burst_ram
    import axi4_burst_ram_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 16,
    parameter int ID_WIDTH = 8,
    localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ID_WIDTH-1:0]   s_axi_awid,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [7:0]            s_axi_awlen,
    input  logic [2:0]            s_axi_awsize,
    input  logic [1:0]            s_axi_awburst,
    input  logic                  s_axi_awlock,
    input  logic [3:0]            s_axi_awcache,
    input  logic [2:0]            s_axi_awprot,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [DATA_WIDTH-1:0] s_axi_wdata,
    input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
    input  logic                  s_axi_wlast,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [ID_WIDTH-1:0]   s_axi_bid,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ID_WIDTH-1:0]   s_axi_arid,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [7:0]            s_axi_arlen,
    input  logic [2:0]            s_axi_arsize,
    input  logic [1:0]            s_axi_arburst,
    input  logic                  s_axi_arlock,
    input  logic [3:0]            s_axi_arcache,
    input  logic [2:0]            s_axi_arprot,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [ID_WIDTH-1:0]   s_axi_rid,
    output logic [DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rlast,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready
);
    localparam int OFF = $clog2(STRB_WIDTH);
    localparam int WORDS = 2 ** ADDR_WIDTH / STRB_WIDTH;

    logic [DATA_WIDTH-1:0] mem [0:WORDS-1];

    w_state_t              w_state, w_next;
    logic [ID_WIDTH-1:0]   w_id;
    logic [ADDR_WIDTH-1:0] w_addr, w_addr_nx;
    logic [2:0]            w_size;
    logic [1:0]            w_burst;
    logic [7:0]            w_cnt;
    r_state_t              r_state, r_next;
    logic [ID_WIDTH-1:0]   r_id;
    logic [ADDR_WIDTH-1:0] r_addr, r_addr_nx;
    logic [2:0]            r_size;
    logic [1:0]            r_burst;
    logic [7:0]            r_cnt;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_last;
    // Holds the address-ready outputs low for the cycle reset is asserted and the one it releases on.
    logic                  en;
    logic                  aw_hs, w_hs, ar_hs, r_hs;
    logic                  unused_ok;

    assign unused_ok = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_wlast,
                         s_axi_arlock, s_axi_arcache, s_axi_arprot};

    assign s_axi_awready = (w_state == W_IDLE) && en;
    assign s_axi_wready  = w_state == W_DATA;
    assign s_axi_bvalid  = w_state == W_RESP;
    assign s_axi_bid     = w_id;
    assign s_axi_bresp   = RESP_OKAY;
    assign s_axi_arready = (r_state == R_IDLE) && en;
    assign s_axi_rvalid  = r_state == R_DATA;
    assign s_axi_rid     = r_id;
    assign s_axi_rdata   = r_data;
    assign s_axi_rlast   = r_last;
    assign s_axi_rresp   = RESP_OKAY;

    assign aw_hs = s_axi_awvalid && s_axi_awready;
    assign w_hs  = s_axi_wvalid && s_axi_wready;
    assign ar_hs = s_axi_arvalid && s_axi_arready;
    assign r_hs  = s_axi_rvalid && s_axi_rready;

    axi4_burst_addr_next #(.ADDR_WIDTH(ADDR_WIDTH)) u_w_next (
        .addr(w_addr), .size(w_size), .burst(w_burst), .next(w_addr_nx)
    );
    axi4_burst_addr_next #(.ADDR_WIDTH(ADDR_WIDTH)) u_r_next (
        .addr(r_addr), .size(r_size), .burst(r_burst), .next(r_addr_nx)
    );

    // The write burst ends on the counted (awlen+1)th beat; wlast is not trusted.
    always_comb begin
        w_next = w_state == W_IDLE ? (aw_hs ? W_DATA : W_IDLE) :
                 w_state == W_DATA ? ((w_hs && w_cnt == '0) ? W_RESP : W_DATA) :
                 (s_axi_bready ? W_IDLE : W_RESP);
        r_next = r_state == R_IDLE ? (ar_hs ? R_DATA : R_IDLE) :
                 ((r_hs && r_cnt == '0) ? R_IDLE : R_DATA);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
            r_last  <= 1'b0;
            en      <= 1'b0;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
            en      <= 1'b1;
            if (aw_hs) begin
                w_id    <= s_axi_awid;
                w_addr  <= s_axi_awaddr;
                w_size  <= s_axi_awsize;
                w_burst <= s_axi_awburst;
                w_cnt   <= s_axi_awlen;
            end else if (w_hs) begin
                w_addr <= w_addr_nx;
                w_cnt  <= w_cnt - 8'd1;
            end
            // rdata/rid/rlast only change on a handshake, so they hold while stalled.
            if (ar_hs) begin
                r_id    <= s_axi_arid;
                r_addr  <= s_axi_araddr;
                r_size  <= s_axi_arsize;
                r_burst <= s_axi_arburst;
                r_cnt   <= s_axi_arlen;
                r_data  <= mem[s_axi_araddr[ADDR_WIDTH-1:OFF]];
                r_last  <= s_axi_arlen == '0;
            end else if (r_hs) begin
                r_addr <= r_addr_nx;
                r_cnt  <= r_cnt - 8'd1;
                r_data <= mem[r_addr_nx[ADDR_WIDTH-1:OFF]];
                r_last <= r_cnt == 8'd1;
            end
        end
    end

    // Separate non-blocking write: a same-cycle read of this word sees the old contents.
    always_ff @(posedge clk) begin
        if (w_hs) begin
            for (int i = 0; i < STRB_WIDTH; i++) begin
                if (s_axi_wstrb[i]) mem[w_addr[ADDR_WIDTH-1:OFF]][8*i +: 8] <= s_axi_wdata[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_axi4_burst_ram.sv
// tb_axi4_burst_ram: scoreboard bench for axi4_burst_ram with directed bursts, backpressure and reset
module tb_axi4_burst_ram;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  awid, arid, bid, rid;
    logic [15:0] awaddr, araddr;
    logic [7:0]  awlen, arlen, wstrb;
    logic [2:0]  awsize, arsize, awprot, arprot;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic        awlock, arlock;
    logic [3:0]  awcache, arcache;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic [63:0] wdata, rdata;

    typedef struct packed {
        logic [7:0]  id;
        logic [63:0] data;
        logic        last;
    } rbeat_t;

    rbeat_t      rq[$];
    logic [7:0]  bq[$];
    logic [63:0] wd[16];
    logic [7:0]  ws[16];
    logic [63:0] ed[16];
    int          tests = 0;
    int          fails = 0;
    logic        stall;
    logic [72:0] held;
    rbeat_t      re;
    logic [7:0]  be;
    logic [3:0]  pat;

    always #5 clk = ~clk;

    axi4_burst_ram dut (
        .clk(clk), .rst(rst),
        .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
        .s_axi_awburst(awburst), .s_axi_awlock(awlock), .s_axi_awcache(awcache), .s_axi_awprot(awprot),
        .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
        .s_axi_arburst(arburst), .s_axi_arlock(arlock), .s_axi_arcache(arcache), .s_axi_arprot(arprot),
        .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
        .s_axi_rvalid(rvalid), .s_axi_rready(rready)
    );

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [7:0] id, input logic [15:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input int nbeats);
        int n;
        awid = id; awaddr = addr; awlen = len; awsize = 3'd3; awburst = burst; awvalid = 1'b1;
        n = 0;
        while (!awready && n < 50) begin tick; n++; end
        check("aw_handshake", 80'(awready), 80'(1));
        tick;
        awvalid = 1'b0;
        if (nbeats == int'(len) + 1) bq.push_back(id);
        for (int b = 0; b < nbeats; b++) begin
            wdata = wd[b]; wstrb = ws[b]; wlast = (b == int'(len)); wvalid = 1'b1;
            n = 0;
            while (!wready && n < 50) begin tick; n++; end
            check("w_handshake", 80'(wready), 80'(1));
            tick;
        end
        wvalid = 1'b0;
        wlast = 1'b0;
    endtask

    task automatic do_read(input logic [7:0] id, input logic [15:0] addr, input logic [7:0] len,
                           input logic [1:0] burst);
        int n;
        for (int b = 0; b <= int'(len); b++) rq.push_back(rbeat_t'{id, ed[b], b == int'(len)});
        arid = id; araddr = addr; arlen = len; arsize = 3'd3; arburst = burst; arvalid = 1'b1;
        n = 0;
        while (!arready && n < 50) begin tick; n++; end
        check("ar_handshake", 80'(arready), 80'(1));
        tick;
        arvalid = 1'b0;
    endtask

    task automatic drain;
        int n = 0;
        while ((rq.size() != 0 || bq.size() != 0) && n < 200) begin tick; n++; end
        check("drain_pending", 80'(rq.size() + bq.size()), 80'(0));
    endtask

    always @(negedge clk) begin
        if (rst) begin
            stall <= 1'b0;
        end else begin
            if (stall) check("r_hold", {rvalid, rid, rdata, rlast}, {1'b1, held});
            if (bvalid && bready) begin
                if (bq.size() == 0) check("b_unexpected", 80'(bvalid), 80'(0));
                else begin
                    be = bq.pop_front();
                    check("b_resp", {bid, bresp}, {be, 2'b00});
                end
            end
            if (rvalid && rready) begin
                if (rq.size() == 0) check("r_unexpected", 80'(rvalid), 80'(0));
                else begin
                    re = rq.pop_front();
                    check("r_beat", {rid, rdata, rlast, rresp}, {re, 2'b00});
                end
            end
            stall <= rvalid && !rready;
            held  <= {rid, rdata, rlast};
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        {awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid} = '0;
        {wdata, wstrb, wlast, wvalid} = '0;
        {arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid} = '0;
        bready = 1'b1; rready = 1'b1; pat = 4'b1001;
        rst = 1'b1;
        tick; tick;
        check("reset_outputs", 80'({awready, wready, bvalid, arready, rvalid, rlast}), 80'(0));
        rst = 1'b0;
        tick;
        check("idle_ready", 80'({awready, arready}), 80'(2'b11));

        wd[0] = 64'h1122334455667788; ws[0] = 8'hFF;
        do_write(8'h5A, 16'h0010, 8'd0, 2'b01, 1);
        drain;
        ed[0] = 64'h1122334455667788;
        do_read(8'h33, 16'h0010, 8'd0, 2'b01);
        check("r_first_latency", 80'(rvalid), 80'(1));
        drain;

        for (int b = 0; b < 4; b++) begin wd[b] = 64'(b + 1); ws[b] = 8'hFF; ed[b] = 64'(b + 1); end
        do_write(8'h01, 16'h0100, 8'd3, 2'b01, 4);
        drain;
        do_read(8'h02, 16'h0100, 8'd3, 2'b01);
        drain;

        wd[0] = '1; ws[0] = 8'hFF;
        do_write(8'h03, 16'h0300, 8'd0, 2'b01, 1);
        wd[0] = '0; ws[0] = 8'h0F;
        do_write(8'h04, 16'h0300, 8'd0, 2'b01, 1);
        drain;
        ed[0] = 64'hFFFFFFFF00000000;
        do_read(8'h05, 16'h0300, 8'd0, 2'b01);
        drain;

        for (int b = 0; b < 4; b++) ed[b] = 64'(b + 1);
        do_read(8'h44, 16'h0100, 8'd3, 2'b01);
        for (int k = 0; k < 100 && rq.size() != 0; k++) begin
            rready = pat[k % 4];
            tick;
        end
        rready = 1'b1;
        drain;

        bready = 1'b0;
        wd[0] = 64'hCAFE; ws[0] = 8'hFF;
        do_write(8'h06, 16'h0600, 8'd0, 2'b01, 1);
        for (int i = 0; i < 5; i++) begin
            check("b_backpressure", 80'({bvalid, awready}), 80'(2'b10));
            tick;
        end
        bready = 1'b1;
        drain;

        wd[0] = 64'hDEAD;
        do_write(8'h07, 16'h0208, 8'd0, 2'b01, 1);
        wd[0] = 64'hA; wd[1] = 64'hB; wd[2] = 64'hC;
        ws[0] = 8'hFF; ws[1] = 8'hFF; ws[2] = 8'hFF;
        do_write(8'h08, 16'h0200, 8'd2, 2'b00, 3);
        drain;
        ed[0] = 64'hC; ed[1] = 64'hDEAD;
        do_read(8'h09, 16'h0200, 8'd1, 2'b01);
        drain;

        wd[0] = 64'h77; wd[1] = 64'h88;
        do_write(8'h0A, 16'h0400, 8'd3, 2'b01, 2);
        rst = 1'b1;
        tick;
        check("reset_mid_burst", 80'({awready, wready, bvalid, arready, rvalid, rlast}), 80'(0));
        rst = 1'b0;
        tick;
        check("post_reset_awready", 80'(awready), 80'(1));
        ed[0] = 64'h77; ed[1] = 64'h88;
        do_read(8'h0B, 16'h0400, 8'd1, 2'b01);
        drain;
        wd[0] = 64'h0123456789ABCDEF;
        do_write(8'h0C, 16'h0500, 8'd0, 2'b01, 1);
        drain;
        ed[0] = 64'h0123456789ABCDEF;
        do_read(8'h0D, 16'h0500, 8'd0, 2'b01);
        drain;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/axi4_burst_ram.md
Name: axi4_burst_ram

Overview:
- Single-port-array AXI4 slave memory with independent read and write channels, used as the main system RAM behind the core's AXI interconnect in simulation.
- Supports full AXI4 bursts with per-byte write strobes.
- The storage array can be preloaded by hierarchical $readmemh on an array named mem.

Parameters:
- DATA_WIDTH, 64, data bus width in bits; multiple of 8.
- ADDR_WIDTH, 16, byte-address width; memory size is 2**ADDR_WIDTH bytes.
- ID_WIDTH, 8, AXI ID width.
- STRB_WIDTH, DATA_WIDTH/8, derived localparam; not overridable.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- s_axi_awid/awaddr/awlen/awsize/awburst  in  ID_WIDTH/ADDR_WIDTH/8/3/2  write address
- s_axi_awlock/awcache/awprot  in  1/4/3  accepted, ignored
- s_axi_awvalid in 1; s_axi_awready out 1
- s_axi_wdata/wstrb/wlast  in  DATA_WIDTH/STRB_WIDTH/1  write data
- s_axi_wvalid in 1; s_axi_wready out 1
- s_axi_bid out ID_WIDTH; s_axi_bresp out 2; s_axi_bvalid out 1; s_axi_bready in 1
- s_axi_arid/araddr/arlen/arsize/arburst  in  ID_WIDTH/ADDR_WIDTH/8/3/2  read address
- s_axi_arlock/arcache/arprot  in  1/4/3  ignored
- s_axi_arvalid in 1; s_axi_arready out 1
- s_axi_rid out ID_WIDTH; s_axi_rdata out DATA_WIDTH; s_axi_rresp out 2; s_axi_rlast out 1; s_axi_rvalid out 1; s_axi_rready in 1

Behaviour:
- Storage: reg array mem[0 : 2**ADDR_WIDTH/STRB_WIDTH-1] of DATA_WIDTH bits. Word index = addr[ADDR_WIDTH-1 : log2(STRB_WIDTH)]. Not cleared by reset.
- Reset (synchronous): awready=0, wready=0, bvalid=0, arready=0, rvalid=0, rlast=0. bresp and rresp are always 2'b00 (OKAY). Both FSMs go to IDLE.
- Write FSM states: W_IDLE, W_DATA, W_RESP.
  - W_IDLE: awready=1. On awvalid, latch id, addr, size, burst and count=awlen, then go to W_DATA.
  - W_DATA: wready=1. Each wvalid&&wready beat writes mem byte lanes where wstrb[i]=1, then advances the address.
  - Final beat is counted, i.e. the (awlen+1)th beat; wlast is ignored.
  - After the final beat, go to W_RESP with bvalid=1 and bid = latched id.
  - W_RESP: hold bvalid until bready, then return to W_IDLE. The earliest next awready is the cycle after the B handshake.
- Read FSM states: R_IDLE, R_DATA.
  - R_IDLE: arready=1. On arvalid, latch fields and go to R_DATA.
  - R_DATA: registered data; the first rvalid appears 1 cycle after the AR handshake. rdata = mem[word(addr)], rid = latched id, rlast=1 on beat arlen+1.
  - While rvalid && !rready, rdata, rid and rlast stay stable.
  - On rvalid&&rready, advance and present the next beat the following cycle. rvalid may stay high back-to-back, giving 1 beat per cycle.
  - After the last beat, return to R_IDLE.
- Address advance:
  - FIXED (00): no change.
  - INCR (01): addr += 1<<size.
  - WRAP (10): treated as INCR.
  - Reserved (11): treated as INCR.
  - Address arithmetic is modulo 2**ADDR_WIDTH; it wraps around the memory.
- Read and write channels operate fully concurrently. On a same-cycle read and write to the same word, the read returns the pre-write data.
- Reset asserted mid-burst aborts the burst: no B or R response is issued, and memory already written stays written.

Decomposition:
- Package axi4_burst_ram_pkg holds:
  - burst encodings BURST_FIXED/INCR/WRAP;
  - RESP_OKAY;
  - write-FSM and read-FSM state enums.
- One natural sub-module, axi4_burst_addr_next: combinational next-address calculator (addr, size, burst → next addr), instantiated once per channel.

Test Plan:
- Single write: AW addr 0x0010 len 0 size 3, W data 0x1122334455667788 strb 0xFF → bvalid with bid = awid, bresp=0. Then AR 0x0010 → rdata 0x1122334455667788, rlast=1, rvalid 1 cycle after AR handshake.
- INCR write burst: len 3 size 3 from 0x0100, data 1,2,3,4 → reads of 0x0100, 0x0108, 0x0110, 0x0118 return 1..4; rlast only on the 4th beat.
- Strobe test: preload word 0xFFFFFFFFFFFFFFFF, write 0x0 with strb 0x0F → read returns 0xFFFFFFFF00000000.
- Backpressure: 4-beat read with rready toggling 1,0,0,1,… → no beat is lost or duplicated, and rdata/rid/rlast are held while stalled. Hold bready=0 for 5 cycles → bvalid stays 1 and awready stays 0.
- FIXED burst: write len 2 to 0x0200 with data A,B,C → the word at 0x0200 holds C, and 0x0208 is unchanged.
- Reset: assert rst mid write burst → next cycle all valid and ready outputs are 0. After deassert, awready=1 and a new transaction completes normally.
